// File: rtl/estagio_id_ex.sv
// -----------------------------------------------------------------------------
// estagio_id_ex -- ID/EX pipeline register that sits directly in front of the ALU
//
// Purpose:
//   This module captures the decoded operands and control bits from the decode
//   stage. Before they are registered, it does two things:
//     * It selects ALU operand 2, which is either the register value (rt) or
//       the sign-extended immediate.
//     * It decodes alu_op/funct into the 4-bit ALU control code. It also flags
//       funct values it does not recognise.
//   The module also supports stall (hold), flush (insert a bubble) and a
//   saturating counter of bubbles.
//
// Optional feature (compile-time macro ESTAGIO_ID_EX_FORWARDING_EN):
//   When defined, the writeback value is forwarded into operand 1 and/or
//   operand 2. This happens when writeback targets rs/rt and the target is not
//   register 0. The immediate path is never forwarded.
//   When undefined, the wb_* ports exist but are ignored.
//
// Ports:
//   clock                 in   rising-edge clock
//   reset                 in   asynchronous active-low reset (0 = reset)
//   dado1_in / dado2_in   in   register file read ports (rs / rt)
//   imediato_in           in   sign-extended immediate
//   rs_in, rt_in, rd_in   in   register indices
//   alu_op_in, funct_in   in   ALU op class and funct field
//   alu_src_in            in   1 = immediate as operand 2
//   reg_write_in, mem_read_in, mem_write_in, branch_in  in  control bits
//   valido_in             in   decode stage holds a real instruction
//   stall                 in   hold every register
//   flush                 in   insert bubble (wins over stall)
//   wb_escreve, wb_reg, wb_dado  in  writeback bus (forwarding source)
//   data1                 out  ALU operand 1
//   saida_mux_registrador out  ALU operand 2
//   saida_alu_control     out  ALU operation code
//   dado_escrita          out  rt value for stores
//   rd_out                out  destination register index
//   reg_write, mem_read, mem_write, branch, valido  out  registered control
//   funct_ilegal          out  registered illegal-funct flag
//   contador_bolhas       out  saturating bubble counter
// -----------------------------------------------------------------------------
module estagio_id_ex #(
    parameter int LARGURA          = 32,
    parameter int LARGURA_CONTADOR = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [LARGURA-1:0]          dado1_in,
    input  logic [LARGURA-1:0]          dado2_in,
    input  logic [LARGURA-1:0]          imediato_in,
    input  logic [4:0]                  rs_in,
    input  logic [4:0]                  rt_in,
    input  logic [4:0]                  rd_in,
    input  logic [1:0]                  alu_op_in,
    input  logic [5:0]                  funct_in,
    input  logic                        alu_src_in,
    input  logic                        reg_write_in,
    input  logic                        mem_read_in,
    input  logic                        mem_write_in,
    input  logic                        branch_in,
    input  logic                        valido_in,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        wb_escreve,
    input  logic [4:0]                  wb_reg,
    input  logic [LARGURA-1:0]          wb_dado,
    output logic [LARGURA-1:0]          data1,
    output logic [LARGURA-1:0]          saida_mux_registrador,
    output logic [3:0]                  saida_alu_control,
    output logic [LARGURA-1:0]          dado_escrita,
    output logic [4:0]                  rd_out,
    output logic                        reg_write,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic                        branch,
    output logic                        valido,
    output logic                        funct_ilegal,
    output logic [LARGURA_CONTADOR-1:0] contador_bolhas
);

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // R-type funct encodings
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    // -------------------------------------------------------------------------
    // Operand selection (optional writeback forwarding)
    // -------------------------------------------------------------------------
    logic [LARGURA-1:0] operando1;
    logic [LARGURA-1:0] operando2;

`ifdef ESTAGIO_ID_EX_FORWARDING_EN
    logic encaminha_rs;
    logic encaminha_rt;

    // Register 0 is hardwired to zero, so a writeback to it is never forwarded.
    assign encaminha_rs = wb_escreve && (wb_reg != 5'd0) && (wb_reg == rs_in);
    assign encaminha_rt = wb_escreve && (wb_reg != 5'd0) && (wb_reg == rt_in);
    assign operando1    = encaminha_rs ? wb_dado : dado1_in;
    assign operando2    = encaminha_rt ? wb_dado : dado2_in;
`else
    assign operando1 = dado1_in;
    assign operando2 = dado2_in;

    // The writeback bus and source indices have no function in this build.
    logic unused_encaminhamento;
    assign unused_encaminhamento = &{1'b0, wb_escreve, wb_reg, wb_dado, rs_in, rt_in};
`endif

    // -------------------------------------------------------------------------
    // ALU control decode
    // -------------------------------------------------------------------------
    logic [3:0] alu_control_d;
    logic       funct_desconhecido;

    always_comb begin
        alu_control_d      = ALU_ADD;
        funct_desconhecido = 1'b0;
        case (alu_op_in)
            2'b00: alu_control_d = ALU_ADD;   // load/store address
            2'b01: alu_control_d = ALU_SUB;   // branch compare
            2'b11: alu_control_d = ALU_OR;    // immediate OR
            default: begin                    // 2'b10: R-type, decode funct
                case (funct_in)
                    FUNCT_ADD: alu_control_d = ALU_ADD;
                    FUNCT_SUB: alu_control_d = ALU_SUB;
                    FUNCT_AND: alu_control_d = ALU_AND;
                    FUNCT_OR:  alu_control_d = ALU_OR;
                    FUNCT_SLT: alu_control_d = ALU_SLT;
                    FUNCT_NOR: alu_control_d = ALU_NOR;
                    default: begin
                        alu_control_d      = ALU_ADD;
                        funct_desconhecido = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // An unknown R-type funct must not have side effects downstream. Its
    // control bits are suppressed. The flag is only raised for real
    // instructions.
    logic funct_ilegal_d;
    logic controle_ok;

    assign funct_ilegal_d = funct_desconhecido && valido_in;
    assign controle_ok    = !funct_desconhecido;

    // -------------------------------------------------------------------------
    // Pipeline registers
    // -------------------------------------------------------------------------
    logic [LARGURA-1:0]          data1_q;
    logic [LARGURA-1:0]          mux_q;
    logic [3:0]                  alu_control_q;
    logic [LARGURA-1:0]          dado_escrita_q;
    logic [4:0]                  rd_q;
    logic                        reg_write_q;
    logic                        mem_read_q;
    logic                        mem_write_q;
    logic                        branch_q;
    logic                        valido_q;
    logic                        funct_ilegal_q;
    logic [LARGURA_CONTADOR-1:0] contador_q;

    // Bubble counter stops at all-ones instead of wrapping.
    logic [LARGURA_CONTADOR-1:0] contador_inc;
    assign contador_inc = (&contador_q) ? contador_q
                                        : contador_q + LARGURA_CONTADOR'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data1_q        <= '0;
            mux_q          <= '0;
            alu_control_q  <= '0;
            dado_escrita_q <= '0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            branch_q       <= 1'b0;
            valido_q       <= 1'b0;
            funct_ilegal_q <= 1'b0;
            contador_q     <= '0;
        end else if (flush) begin
            // A bubble still presents a harmless ADD code to the ALU.
            data1_q        <= '0;
            mux_q          <= '0;
            alu_control_q  <= ALU_ADD;
            dado_escrita_q <= '0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            branch_q       <= 1'b0;
            valido_q       <= 1'b0;
            funct_ilegal_q <= 1'b0;
            contador_q     <= contador_inc;
        end else if (!stall) begin
            data1_q        <= operando1;
            mux_q          <= alu_src_in ? imediato_in : operando2;
            alu_control_q  <= alu_control_d;
            dado_escrita_q <= operando2;
            rd_q           <= rd_in;
            reg_write_q    <= reg_write_in && controle_ok;
            mem_read_q     <= mem_read_in  && controle_ok;
            mem_write_q    <= mem_write_in && controle_ok;
            branch_q       <= branch_in    && controle_ok;
            valido_q       <= valido_in;
            funct_ilegal_q <= funct_ilegal_d;
            if (!valido_in) begin
                contador_q <= contador_inc;
            end
        end
    end

    assign data1                 = data1_q;
    assign saida_mux_registrador = mux_q;
    assign saida_alu_control     = alu_control_q;
    assign dado_escrita          = dado_escrita_q;
    assign rd_out                = rd_q;
    assign reg_write             = reg_write_q;
    assign mem_read              = mem_read_q;
    assign mem_write             = mem_write_q;
    assign branch                = branch_q;
    assign valido                = valido_q;
    assign funct_ilegal          = funct_ilegal_q;
    assign contador_bolhas       = contador_q;

endmodule

// File: doc/estagio_id_ex.md
Name: estagio_id_ex

Overview:
ID/EX pipeline register directly upstream of the ALU. Captures decoded operands and control from the decode stage and does two things before registering them: selects the second operand (register or immediate), and decodes alu_op/funct into the 4-bit ALU control code. Its registered outputs drive the ALU's data1, saida_mux_registrador and saida_alu_control inputs, plus the control bits later stages need. Supports stall, flush and bubble counting.

Parameters:
LARGURA, 32, datapath width of operands and immediate
LARGURA_CONTADOR, 16, width of saturating bubble counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
dado1_in  input  LARGURA  register file read port 1 (rs)
dado2_in  input  LARGURA  register file read port 2 (rt)
imediato_in  input  LARGURA  sign-extended immediate
rs_in, rt_in, rd_in  input  5 each  register indices
alu_op_in  input  2  main-control ALU op class
funct_in  input  6  instruction funct field
alu_src_in  input  1  1 = immediate as operand 2
reg_write_in, mem_read_in, mem_write_in, branch_in  input  1 each  control bits
valido_in  input  1  decode stage holds a real instruction
stall  input  1  hold all registers
flush  input  1  insert bubble
wb_escreve  input  1  writeback write enable (forwarding)
wb_reg  input  5  writeback destination
wb_dado  input  LARGURA  writeback value
data1  output  LARGURA  ALU operand 1
saida_mux_registrador  output  LARGURA  ALU operand 2
saida_alu_control  output  4  ALU operation code
dado_escrita  output  LARGURA  rt value for stores
rd_out  output  5  destination index
reg_write, mem_read, mem_write, branch, valido  output  1 each  registered control
funct_ilegal  output  1  registered illegal-funct flag
contador_bolhas  output  LARGURA_CONTADOR  bubble count

Behaviour:
- Reset (reset=0, asynchronous): every output = 0, including contador_bolhas.
- Update priority at each rising edge: reset > flush > stall > load. Latency: 1 clock from inputs to outputs.
- Load: every output takes its next value from the current inputs.
  - data1 <= operand1.
  - saida_mux_registrador <= imediato_in when alu_src_in=1, otherwise operand2.
  - dado_escrita <= operand2.
  - Control bits, rd_out and valido are copied from the inputs.
- Flush: all control outputs, valido, funct_ilegal, data and rd_out = 0. saida_alu_control = 0010. Flush wins over a simultaneous stall.
- Stall without flush: every output holds its value, and contador_bolhas does not change.
- ALU control decode (registered on load):
  - alu_op 00 -> 0010
  - alu_op 01 -> 0110
  - alu_op 11 -> 0001
  - alu_op 10 decodes funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100.
  - Any other funct under alu_op 10 -> 0010 and funct_ilegal=1. Also, in that case reg_write, mem_read, mem_write and branch are forced to 0.
- funct_ilegal is 0 for every alu_op other than 10, and 0 when valido_in=0.
- Bubble counter:
  - Increments by 1 on each non-stalled edge whose new valido is 0 (flush or valido_in=0).
  - Saturates at all-ones; no wrap.
- Without forwarding, operand1 = dado1_in and operand2 = dado2_in.

Optional Feature:
Macro: ESTAGIO_ID_EX_FORWARDING_EN
- Defined:
  - operand1 = wb_dado when wb_escreve=1, wb_reg!=0 and wb_reg==rs_in; otherwise dado1_in.
  - operand2 = wb_dado under the same rule with rt_in; otherwise dado2_in.
  - The immediate path is never forwarded.
- Undefined: the wb_* ports are present but ignored; no forwarding logic.

Test Plan:
1. Reset low mid-operation with outputs nonzero -> all outputs 0 immediately without a clock edge. Release, then load alu_op=10, funct=100010, dado1=10, dado2=3 -> next edge: data1=10, saida_mux_registrador=3, saida_alu_control=0110, valido=1.
2. alu_src=1, imediato=0xFFFFFFFC, alu_op=00 -> saida_mux_registrador=0xFFFFFFFC, code 0010. alu_op=10, funct=100111 -> code 1100. funct=101010 -> code 0111.
3. alu_op=10, funct=000011, reg_write_in=1 -> funct_ilegal=1, reg_write=0, code 0010.
4. stall=1 for 3 cycles while inputs change -> outputs frozen and counter unchanged. stall=1 with flush=1 -> bubble: valido=0, counter +1.
5. valido_in=0 for 2^LARGURA_CONTADOR+5 cycles (test LARGURA_CONTADOR=4) -> contador_bolhas stops at 15.
6. With the macro: wb_escreve=1, wb_reg=rs=5, wb_dado=0x1234 -> data1=0x1234. wb_reg=0 -> no forward. Without the macro -> data1=dado1_in.
